// File: rtl/golden_nonce_pkg.sv
// Shared definitions for the golden-nonce transmit queue.
//   GN_BYTES   : bytes per nonce frame on the serial link
//   BYTE_IDX_W : width of the byte-within-frame index
//   gn_state_e : transmit FSM state encoding
package golden_nonce_pkg;

  localparam int unsigned GN_BYTES   = 4;
  localparam int unsigned BYTE_IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } gn_state_e;

endpackage

// File: rtl/gn_sync_fifo.sv
// Single-clock FIFO used to buffer golden nonces.
// A push while full is accepted when a pop happens in the same cycle.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   clear_i       : synchronous clear of pointers and count
//   push_i, din_i : write request and data
//   pop_i, dout_o : read request and head-of-queue data
//   count_o       : number of stored entries
//   full_o        : count_o == DEPTH
module gn_sync_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      din_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      dout_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign full_o  = count_q[DEPTH_LOG2];
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && (count_q != '0) && !clear_i;
  assign do_push = push_i && (!full_o || do_pop) && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count/pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/golden_nonce_tx_queue.sv
// Queues golden-nonce match strobes and drains each nonce as four bytes,
// least-significant first, over a valid/ready byte handshake.
// Ports:
//   hash_clk, reset       : clock, asynchronous active-high reset
//   flush                 : synchronous clear of queue and overflow count
//   gn_in, gn_valid       : nonce and one-cycle match strobe
//   tx_data, tx_valid,
//   tx_ready              : byte stream to the UART transmitter
//   fifo_count            : queued entries (not counting the one being sent)
//   overflow_cnt          : saturating count of dropped nonces
//   empty                 : nothing queued and FSM idle
module golden_nonce_tx_queue
  import golden_nonce_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned OVF_W      = 8
) (
  input  logic                  hash_clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [31:0]           gn_in,
  input  logic                  gn_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic [OVF_W-1:0]      overflow_cnt,
  output logic                  empty
);

  gn_state_e              state_q, state_d;
  logic [31:0]            shifter_q, shifter_d;
  logic [BYTE_IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [OVF_W-1:0]       ovf_q, ovf_d;
  logic                   push_req, pop, fifo_full, drop;
  logic [31:0]            fifo_dout;

  assign push_req = gn_valid && !flush;
  assign drop     = push_req && fifo_full && !pop;

  gn_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (32)
  ) u_fifo (
    .clk_i   (hash_clk),
    .rst_i   (reset),
    .clear_i (flush),
    .push_i  (push_req),
    .din_i   (gn_in),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full)
  );

  assign tx_data      = shifter_q[7:0];
  assign overflow_cnt = ovf_q;
  assign empty        = (fifo_count == '0) && (state_q == IDLE);

  always_comb begin
    ovf_d = ovf_q;
    if (flush)                   ovf_d = '0;
    else if (drop && ovf_q != '1) ovf_d = ovf_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    shifter_d  = shifter_q;
    byte_idx_d = byte_idx_q;
    pop        = 1'b0;
    tx_valid   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // No new frame is started in a flush cycle: the queue is being discarded.
        if (fifo_count != '0 && !flush) begin
          pop        = 1'b1;
          shifter_d  = fifo_dout;
          byte_idx_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          shifter_d  = {8'h00, shifter_q[31:8]};
          byte_idx_d = byte_idx_q + 1'b1;
          if (byte_idx_q == BYTE_IDX_W'(GN_BYTES - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shifter_q  <= '0;
      byte_idx_q <= '0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      shifter_q  <= shifter_d;
      byte_idx_q <= byte_idx_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule
